// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: clears the register file, then arbitrates round-robin writeback from A and B.
module regfile_write_scheduler #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Clear,
    input  logic              ReqA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] DataA,
    output logic              RdyA,
    input  logic              ReqB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] DataB,
    output logic              RdyB,
    output logic              RegWr,
    output logic [ADDR_W-1:0] Waddr,
    output logic [DATA_W-1:0] Writedata,
    output logic              InitDone,
    output logic              AddrErr
);
    localparam int CW = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_prio_b;
    logic              w_last, w_run, w_grant, w_err;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= S_CLEAR;
            r_cnt     <= '0;
            r_prio_b  <= 1'b0;
            RegWr     <= 1'b0;
            Waddr     <= '0;
            Writedata <= '0;
            InitDone  <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            r_state  <= w_next;
            InitDone <= w_next == S_RUN;
            if (r_state == S_CLEAR) begin
                r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
                RegWr     <= 1'b1;
                Waddr     <= ADDR_W'(r_cnt);
                Writedata <= '0;
                AddrErr   <= 1'b0;
            end else if (Clear) begin
                r_cnt   <= '0;
                RegWr   <= 1'b0;
                AddrErr <= 1'b0;
            end else begin
                // an out-of-range request is still consumed, only the file write is suppressed
                RegWr   <= w_grant && !w_err;
                AddrErr <= w_grant && w_err;
                if (w_grant) begin
                    Waddr     <= w_addr;
                    Writedata <= w_data;
                    r_prio_b  <= RdyA;
                end
            end
        end
    end

    always_comb begin
        w_last = r_cnt == CW'(NUM_REGS - 1);
        w_next = r_state == S_CLEAR ? (w_last ? S_RUN : S_CLEAR) : (Clear ? S_CLEAR : S_RUN);
    end

    always_comb begin
        w_run   = r_state == S_RUN && !Clear;
        RdyA    = w_run && ReqA && (!ReqB || !r_prio_b);
        RdyB    = w_run && ReqB && (!ReqA || r_prio_b);
        w_grant = RdyA || RdyB;
        w_addr  = RdyB ? AddrB : AddrA;
        w_data  = RdyB ? DataB : DataA;
        w_err   = {1'b0, w_addr} >= LIMIT;
    end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: randomized scoreboard bench for regfile_write_scheduler.
module tb_regfile_write_scheduler;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 0, RESET = 0, Clear = 0, ReqA = 0, ReqB = 0;
    logic [AW-1:0] AddrA = 0, AddrB = 0;
    logic [DW-1:0] DataA = 0, DataB = 0;
    logic          RdyA, RdyB, RegWr, InitDone, AddrErr;
    logic [AW-1:0] Waddr;
    logic [DW-1:0] Writedata;

    regfile_write_scheduler #(.NUM_REGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RESET(RESET), .Clear(Clear),
        .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .RdyA(RdyA),
        .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .RdyB(RdyB),
        .RegWr(RegWr), .Waddr(Waddr), .Writedata(Writedata),
        .InitDone(InitDone), .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          err;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    wr_t           push_e;
    int            tests = 0, fails = 0;
    int            clear_left = N;
    bit            last_b = 1, gnt_a = 0, gnt_b = 0, started = 0;
    logic          d_reqa = 0, d_reqb = 0;
    logic [AW-1:0] d_addra = 0, d_addrb = 0;
    logic [DW-1:0] d_dataa = 0, d_datab = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write or error pulse the DUT shows must be the next expected transfer.
    always @(negedge CLK) begin
        if (RegWr === 1'b1 || AddrErr === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h, none expected", Waddr, Writedata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_err", {RegWr, AddrErr}, {!mon_e.err, mon_e.err});
                chk("waddr", Waddr, mon_e.addr);
                chk("wdata", Writedata, mon_e.data);
            end
        end
    end

    // Reference: a pending-clear countdown plus "who was served last".
    task automatic model();
        if (started) chk("init_done", InitDone, clear_left == 0);
        if (!RESET) begin
            started    = 1;
            clear_left = N;
            last_b     = 1;
            gnt_a      = 0;
            gnt_b      = 0;
            return;
        end
        gnt_a = 0;
        gnt_b = 0;
        if (clear_left > 0 || Clear) begin
            chk("rdy_a_blocked", RdyA, 0);
            chk("rdy_b_blocked", RdyB, 0);
            if (clear_left > 0) begin
                push_e = {1'b0, AW'(N - clear_left), DW'(0)};
                exp_q.push_back(push_e);
                clear_left--;
            end else clear_left = N;
            return;
        end
        gnt_a = ReqA && (!ReqB || last_b);
        gnt_b = ReqB && (!ReqA || !last_b);
        chk("rdy_a", RdyA, gnt_a);
        chk("rdy_b", RdyB, gnt_b);
        if (gnt_a) begin
            push_e = {AddrA >= AW'(N), AddrA, DataA};
            exp_q.push_back(push_e);
            last_b = 0;
        end
        if (gnt_b) begin
            push_e = {AddrB >= AW'(N), AddrB, DataB};
            exp_q.push_back(push_e);
            last_b = 1;
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom % 5 == 0) ? AW'($urandom_range(N, 31)) : AW'($urandom % N);
    endfunction

    // mode 0: drop requests, 1: random requests obeying hold-until-ready, 2: directed d_* values
    task automatic step(input bit rst_n, input bit clr, input int mode);
        @(posedge CLK);
        #1;
        RESET = rst_n;
        Clear = clr;
        if (mode == 2) begin
            ReqA = d_reqa; AddrA = d_addra; DataA = d_dataa;
            ReqB = d_reqb; AddrB = d_addrb; DataB = d_datab;
        end else if (mode == 0) begin
            ReqA = 0;
            ReqB = 0;
        end else begin
            if (gnt_a || !ReqA) begin
                ReqA = $urandom % 3 != 0; AddrA = rnd_addr(); DataA = $urandom;
            end
            if (gnt_b || !ReqB) begin
                ReqB = $urandom % 3 != 0; AddrB = rnd_addr(); DataB = $urandom;
            end
        end
        #3 model();
    endtask

    initial begin
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_regwr", RegWr, 0);
        chk("rst_waddr", Waddr, 0);
        chk("rst_wdata", Writedata, 0);
        chk("rst_initdone", InitDone, 0);
        chk("rst_addrerr", AddrErr, 0);
        repeat (20) step(1, 0, 0);
        d_reqa = 1; d_addra = 3; d_dataa = 5; d_reqb = 0;
        step(1, 0, 2);
        repeat (3) step(1, 0, 0);
        d_reqa = 1; d_addra = 1; d_dataa = 10; d_reqb = 1; d_addrb = 2; d_datab = 20;
        repeat (4) step(1, 0, 2);
        repeat (2) step(1, 0, 0);
        d_reqa = 0; d_reqb = 1; d_addrb = 20; d_datab = 32'hdead;
        step(1, 0, 2);
        repeat (3) step(1, 0, 0);
        d_reqa = 1; d_addra = 7; d_dataa = 32'h55; d_reqb = 0;
        step(1, 1, 2);
        repeat (18) step(1, 0, 2);
        repeat (2) step(1, 0, 0);
        step(1, 1, 0);
        repeat (7) step(1, 0, 0);
        step(0, 0, 0);
        repeat (20) step(1, 0, 0);
        for (int i = 0; i < 600; i++)
            step($urandom % 250 != 0, $urandom % 60 == 0, 1);
        repeat (20) step(1, 0, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
